// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its boot loader.
package cpu_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_DEPTH = 256;

  typedef enum logic [2:0] {
    StIdle,
    StBase,
    StCount,
    StHi,
    StLo,
    StChk,
    StDone,
    StErr
  } ld_state_e;

endpackage

// File: rtl/loader_ckadd.sv
// 8-bit wrapping checksum accumulator; clear has priority over enable.
module loader_ckadd (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (en_i) begin
      sum_d = sum_q + byte_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a BASE/COUNT/words/CHK byte frame into memory writes, then releases the CPU.
module prog_loader
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  ld_state_e state_q, state_d;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [7:0]        hi_q, hi_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              run_q, run_d;

  logic       xfer;
  logic       start_ok;
  logic [7:0] sum;

  assign xfer     = in_valid_i && in_ready_o;
  assign start_ok = start_i && (state_q inside {StIdle, StDone, StErr});

  loader_ckadd u_ckadd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (start_ok),
    .en_i   (xfer && (state_q != StChk)),
    .byte_i (in_data_i),
    .sum_o  (sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (start_i) state_d = StBase;
      StBase:  if (xfer) state_d = StCount;
      StCount: if (xfer) state_d = StHi;
      StHi:    if (xfer) state_d = StLo;
      StLo:    if (xfer) state_d = (remaining_q == 9'd1) ? StChk : StHi;
      StChk:   if (xfer) state_d = (in_data_i == sum) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o = state_q inside {StBase, StCount, StHi, StLo, StChk};
    busy_o     = in_ready_o;
  end

  always_comb begin
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    run_d       = run_q;
    if (start_ok) begin
      done_d      = 1'b0;
      err_d       = 1'b0;
      run_d       = 1'b0;
      remaining_d = 9'd0;
    end
    if (xfer) begin
      unique case (state_q)
        StBase:  ptr_d = in_data_i;
        // COUNT of zero encodes a full 256-word load
        StCount: remaining_d = (in_data_i == 8'h00) ? 9'd256 : {1'b0, in_data_i};
        StHi:    hi_d = in_data_i;
        StLo: begin
          mem_wdata_d = {hi_q, in_data_i};
          mem_addr_d  = ptr_q;
          mem_we_d    = 1'b1;
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 9'd1;
        end
        StChk: begin
          done_d = (in_data_i == sum);
          err_d  = (in_data_i != sum);
          run_d  = (in_data_i == sum);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      remaining_q <= '0;
      hi_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      run_q       <= run_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cpu_run_o   = run_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as bytes are driven.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];
  logic [15:0] words[$];

  prog_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_run_o   (cpu_run),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("mem_addr", {24'd0, mem_addr}, {24'd0, e[23:16]});
        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] base, input bit bad_chk, input int max_gap,
                            input bit mid_start);
    logic [7:0] sum;
    logic [7:0] cnt;
    logic [7:0] addr;
    cnt = 8'(words.size());
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    sum = base;
    send_byte(base, max_gap);
    sum = sum + cnt;
    send_byte(cnt, max_gap);
    if (mid_start) pulse_start();
    addr = base;
    foreach (words[i]) begin
      exp_q.push_back({addr, words[i]});
      addr = addr + 8'd1;
      sum  = sum + words[i][15:8] + words[i][7:0];
      send_byte(words[i][15:8], max_gap);
      send_byte(words[i][7:0], max_gap);
    end
    send_byte(bad_chk ? sum - 8'd1 : sum, max_gap);
  endtask

  task automatic check_end(input string tag, input bit good);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    check({tag, "_done"}, {31'd0, done}, {31'd0, good});
    check({tag, "_run"}, {31'd0, cpu_run}, {31'd0, good});
    check({tag, "_err"}, {31'd0, err}, {31'd0, !good});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic load_demo();
    words.delete();
    words.push_back(16'h027F);
    words.push_back(16'h0404);
    words.push_back(16'h067F);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame, then the same frame with a bad checksum.
    load_demo();
    send_frame(8'h80, 1'b0, 0, 1'b0);
    check_end("good", 1'b1);
    load_demo();
    send_frame(8'h80, 1'b1, 0, 1'b0);
    check_end("badchk", 1'b0);

    // COUNT=0 loads 256 words starting at FF and wrapping to 00.
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(16'(i));
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    check_end("wrap", 1'b1);

    // Random gaps plus a start pulse mid-frame.
    load_demo();
    send_frame(8'h80, 1'b0, 5, 1'b1);
    check_end("gaps", 1'b1);

    // Reset after the 4th data byte: the second word lands, nothing after.
    pulse_start();
    exp_q.push_back({8'h80, 16'h027F});
    exp_q.push_back({8'h81, 16'h0404});
    send_byte(8'h80, 0);
    send_byte(8'h03, 0);
    send_byte(8'h02, 0);
    send_byte(8'h7F, 0);
    send_byte(8'h04, 0);
    send_byte(8'h04, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outputs",
          {in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, done, err}, 32'd0);
    check("midrst_pending", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h06;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_ready", {31'd0, in_ready}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);

    load_demo();
    send_frame(8'h80, 1'b0, 2, 1'b0);
    check_end("fresh", 1'b1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream boot stage for the 16-bit accumulator CPU: accepts a framed byte stream on a valid/ready interface and writes it as 16-bit words into the CPU's 256x16 instruction/data memory. After the checksum verifies, it releases the CPU to start fetching. It is the only memory writer while the CPU is held, and it drives the memory write port directly.

## Interface
- ADDR_W, 8, memory address width (256 words).
- DATA_W, 16, memory word width; the stream carries DATA_W/8 = 2 bytes per word.
- clock  in  1  single system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- cpu_run  out  1  CPU released; fetch from address 0 may proceed.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded with a good checksum (sticky).
- err  out  1  last frame checksum mismatch (sticky).

## Operation
- Frame format, in byte order: BASE (start address), COUNT (word count, 0 means 256), then COUNT words sent high byte first, then CHK.
- CHK must equal the mod-256 sum of BASE, COUNT and every data byte.
- States: IDLE, BASE, COUNT, HI, LO, CHK, DONE, ERR.
- IDLE/DONE/ERR + start -> BASE. On this edge: clear done, err and cpu_run; clear the running sum and the word counter.
- BASE: on transfer, latch the address pointer and add the byte to the sum -> COUNT.
- COUNT: on transfer, latch remaining = (byte==0) ? 256 : byte (9-bit counter) and add to the sum -> HI.
- HI: on transfer, latch the high byte and add to the sum -> LO.
- LO: on transfer, register mem_wdata = {hi, byte} and mem_addr = pointer, and pulse mem_we next cycle.
  - Then increment the pointer modulo 256 (255 wraps to 0) and decrement remaining.
  - If remaining becomes 0 -> CHK, else -> HI.
- CHK: on transfer, compare the byte with the sum.
  - Equal -> DONE, with done=1 and cpu_run=1.
  - Unequal -> ERR, with err=1 and cpu_run=0.
- Words already written are not rolled back on ERR.
- start in BASE..CHK is ignored; the frame continues.
- A transfer occurs only when in_valid && in_ready. in_valid gaps of any length stall the FSM with no side effects. in_data is don't-care when in_valid=0.
- Arithmetic: the sum is 8 bits and wraps; the address pointer is ADDR_W bits and wraps.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, done=0, err=0; state=IDLE.
- Reset mid-frame aborts immediately. No further mem_we is issued.
- in_ready=1 exactly in states BASE..CHK. It is decoded from the registered state, so there is no combinational path from in_valid.
- Peak throughput is one byte per cycle. A word costs 2 accepted bytes.
- mem_we is high for exactly the one cycle after the LO transfer. mem_addr and mem_wdata are valid in that cycle and hold until the next write.
- busy=1 in BASE..CHK.
- cpu_run, done and err update in the cycle after the CHK transfer.
- Minimum frame latency from the start pulse to cpu_run: 3+2N cycles of transfers, plus 1 cycle.

## Structure
- Shared package cpu_pkg: ADDR_W, DATA_W, loader state enum, and MEM_DEPTH=256. The CPU reuses the widths from the same package.
- Natural sub-module: loader_ckadd, an 8-bit wrapping accumulator with clear/enable that keeps the running sum.
- Everything else is one FSM plus datapath registers.

## Test plan
- Good frame: start, then 80 03 02 7F 04 04 06 7F 91.
  - Expect mem_we three times: [80]=027F, [81]=0404, [82]=067F.
  - Then done=1, cpu_run=1, err=0.
- Bad checksum: same frame with CHK=90.
  - Expect the three writes as above, then err=1, cpu_run=0, done=0.
- Wrap and COUNT=0: BASE=FF, COUNT=00, 256 words with data=index.
  - Expect 256 writes, with addresses FF, 00, 01 … FE.
  - Expect done=1 with the correct CHK.
- Backpressure: the good frame with in_valid low for a random 0-5 cycles between bytes.
  - Expect identical writes and final state.
  - Expect no mem_we during gaps other than the post-LO cycle.
- Reset and start abuse:
  - start pulsed mid-frame is ignored.
  - reset_n low after the 4th data byte: expect all outputs zero and no further writes.
  - A fresh frame after reset loads correctly.
